// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the integer register file and its scoreboard.
package regfile_pkg;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_MEM  = 3'd1,
        WB_PCP4 = 3'd2,
        WB_CMP  = 3'd3,
        WB_IMM  = 3'd4
    } wb_src_e;

    localparam int XLEN_DEF    = 32;
    localparam int NREG_DEF    = 32;
    localparam int NRD_DEF     = 2;
    localparam int MAXPEND_DEF = 3;

    // Codes 5-7 are reserved and must not commit anything.
    function automatic logic wb_src_ok(input logic [2:0] src);
        return src <= 3'(WB_IMM);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: per-register outstanding-write counters, sticky error, per-port busy.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int MAXPEND = MAXPEND_DEF,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAXPEND + 1)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Mwk,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_rd,
    input  logic              fire,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    busy,
    output logic              sb_err
);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            sb_err_q, sb_err_d;
    logic [NREG-1:0] inc_vec, dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = Mwk && alloc_en && (alloc_rd == AW'(r));
            dec_vec[r] = fire && (wr_addr == AW'(r));
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        for (int r = 1; r < NREG; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CW'(MAXPEND)) sb_err_d = 1'b1;
                else                          cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) sb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
        cnt_d[0] = '0;
    end

    // A commit landing this cycle releases its own consumer without waiting for the count update.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NRD; i++) begin
            busy[i] = (rs_addr[i*AW +: AW] != '0) &&
                      (cnt_q[rs_addr[i*AW +: AW]] > CW'(dec_vec[rs_addr[i*AW +: AW]]));
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back source mux, same-cycle bypass, hardwired x0 and stall scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int MAXPEND = MAXPEND_DEF,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Mwk,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      busy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [2:0]          wr_src,
    input  logic [XLEN-1:0]     alu_in,
    input  logic [XLEN-1:0]     mem_in,
    input  logic [XLEN-1:0]     imm_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [1:0]          cmp_in,
    output logic [XLEN-1:0]     DB,
    output logic                sb_err
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [XLEN-1:0] db_q, db_d;
    logic [XLEN-1:0] wdata;
    logic            fire;
    logic            unused_cmp_hi;

    assign unused_cmp_hi = cmp_in[1];
    assign fire          = Mwk && wr_en && wb_src_ok(wr_src);

    always_comb begin
        wdata = '0;
        case (wb_src_e'(wr_src))
            WB_ALU:  wdata = alu_in;
            WB_MEM:  wdata = mem_in;
            WB_PCP4: wdata = pc_in + XLEN'(4);
            WB_CMP:  wdata = {{(XLEN-1){1'b0}}, cmp_in[0]};
            WB_IMM:  wdata = imm_in;
            default: wdata = '0;
        endcase
    end

    // DB follows every commit, including writes aimed at x0.
    always_comb begin
        regs_d = regs_q;
        db_d   = db_q;
        if (fire) begin
            db_d = wdata;
            if (wr_addr != '0) regs_d[wr_addr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rs_addr[i*AW +: AW] == '0)
                rd_data[i*XLEN +: XLEN] = '0;
            else if (fire && (wr_addr == rs_addr[i*AW +: AW]))
                rd_data[i*XLEN +: XLEN] = wdata;
            else
                rd_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            regs_q <= '{default: '0};
            db_q   <= '0;
        end else begin
            regs_q <= regs_d;
            db_q   <= db_d;
        end
    end

    assign DB = db_q;

    rf_scoreboard #(
        .NREG    (NREG),
        .NRD     (NRD),
        .MAXPEND (MAXPEND)
    ) u_scoreboard (
        .CLK      (CLK),
        .Reset    (Reset),
        .Mwk      (Mwk),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .fire     (fire),
        .wr_addr  (wr_addr),
        .rs_addr  (rs_addr),
        .busy     (busy),
        .sb_err   (sb_err)
    );

endmodule
